// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: word queue between the host write side and the UART TX core.
// Each entry holds data, parity enable and parity type; words are handed to
// the transmitter one at a time with a Data_Valid pulse paced by its Busy flag.
// Optional status outputs (Fifo_Count, Fifo_Overflow) are built when
// TXFIFO_STATUS_EN is defined.
module uart_tx_fifo #(
  parameter int unsigned DataWIDTH  = 3,
  parameter int unsigned DEPTH_LOG2 = 3,
  parameter int unsigned AFULL_LVL  = 6,
  parameter int unsigned BUSY_TMO   = 4
) (
  input  logic                          Fifo_CLK,
  input  logic                          Fifo_RST,
  input  logic                          Fifo_Flush,
  input  logic                          Fifo_WrEn,
  input  logic [(1 << DataWIDTH)-1:0]   Fifo_Pdata_in,
  input  logic                          Fifo_ParityEn_in,
  input  logic                          Fifo_ParBit_in,
  output logic                          Fifo_Full,
  output logic                          Fifo_AlmostFull,
  output logic                          Fifo_Empty,
  input  logic                          Uart_Busy_in,
  output logic [(1 << DataWIDTH)-1:0]   Fifo_Pdata_out,
  output logic                          Fifo_ParityEn_out,
  output logic                          Fifo_ParBit_out,
  output logic                          Fifo_DataValid
`ifdef TXFIFO_STATUS_EN
  ,
  output logic [DEPTH_LOG2:0]           Fifo_Count,
  output logic                          Fifo_Overflow
`endif
);

  localparam int unsigned DW    = 1 << DataWIDTH;
  localparam int unsigned AW    = DEPTH_LOG2;
  localparam int unsigned PW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned EW    = DW + 2;
  localparam int unsigned TW    = 4;

  localparam logic [PW-1:0] OCC_FULL  = PW'(DEPTH);
  localparam logic [PW-1:0] OCC_AFULL = PW'(AFULL_LVL);
  localparam logic [TW-1:0] TMO_LAST  = TW'(BUSY_TMO - 1);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  logic [1:0]    state_q, state_nxt;
  logic [TW-1:0] tmr_q, tmr_nxt;
  logic          issue_c;
  logic          wr_acc_c;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW-1:0] occ_q, occ_nxt;
  logic [EW-1:0] mem [DEPTH];

  // Reset and flush both block the write; the full flag is the registered one
  assign wr_acc_c = Fifo_WrEn & ~Fifo_Full & ~Fifo_Flush & ~Fifo_RST;

  // FSM state and busy-timeout counter register
  always_ff @(posedge Fifo_CLK) begin
    if (Fifo_RST || Fifo_Flush) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_nxt;
      tmr_q   <= tmr_nxt;
    end
  end

  // Next-state logic; a pop happens only on the IDLE -> WAIT_BUSY issue
  always_comb begin
    state_nxt = state_q;
    tmr_nxt   = tmr_q;
    issue_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!Fifo_Empty && !Uart_Busy_in) begin
          issue_c   = 1'b1;
          tmr_nxt   = '0;
          state_nxt = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (Uart_Busy_in) begin
          state_nxt = ST_WAIT_DONE;
        end else if (tmr_q == TMO_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          tmr_nxt = tmr_q + TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!Uart_Busy_in) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next occupancy; simultaneous write and pop cancel out
  always_comb begin
    occ_nxt = occ_q;
    if (wr_acc_c && !issue_c) begin
      occ_nxt = occ_q + PW'(1);
    end else if (!wr_acc_c && issue_c) begin
      occ_nxt = occ_q - PW'(1);
    end
  end

  // Pointers, occupancy and status flags derived from next occupancy
  always_ff @(posedge Fifo_CLK) begin
    if (Fifo_RST || Fifo_Flush) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      Fifo_Empty      <= 1'b1;
      Fifo_Full       <= 1'b0;
      Fifo_AlmostFull <= 1'b0;
    end else begin
      if (wr_acc_c) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (issue_c)  rd_ptr_q <= rd_ptr_q + PW'(1);
      occ_q           <= occ_nxt;
      Fifo_Empty      <= (occ_nxt == '0);
      Fifo_Full       <= (occ_nxt == OCC_FULL);
      Fifo_AlmostFull <= (occ_nxt >= OCC_AFULL);
    end
  end

  // Storage array; entry layout is {parity type, parity enable, data}
  always_ff @(posedge Fifo_CLK) begin
    if (wr_acc_c) begin
      mem[wr_ptr_q[AW-1:0]] <= {Fifo_ParBit_in, Fifo_ParityEn_in, Fifo_Pdata_in};
    end
  end

  // Output word registers hold the last issued word; flush only kills the strobe
  always_ff @(posedge Fifo_CLK) begin
    if (Fifo_RST) begin
      Fifo_Pdata_out    <= '0;
      Fifo_ParityEn_out <= 1'b0;
      Fifo_ParBit_out   <= 1'b0;
      Fifo_DataValid    <= 1'b0;
    end else if (Fifo_Flush) begin
      Fifo_DataValid <= 1'b0;
    end else begin
      Fifo_DataValid <= issue_c;
      if (issue_c) begin
        {Fifo_ParBit_out, Fifo_ParityEn_out, Fifo_Pdata_out} <= mem[rd_ptr_q[AW-1:0]];
      end
    end
  end

`ifdef TXFIFO_STATUS_EN
  assign Fifo_Count = occ_q;

  // Sticky flag for any write attempted while full
  always_ff @(posedge Fifo_CLK) begin
    if (Fifo_RST || Fifo_Flush) begin
      Fifo_Overflow <= 1'b0;
    end else if (Fifo_WrEn && Fifo_Full) begin
      Fifo_Overflow <= 1'b1;
    end
  end
`else
  // Status outputs and overflow tracking are not built in this configuration
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo (default parameters).
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst, flush, wr, pen, pbit, busy;
  logic [7:0] din;
  logic       full, afull, empty, dv, pen_o, pbit_o;
  logic [7:0] dout;
`ifdef TXFIFO_STATUS_EN
  logic [3:0] count;
  logic       ovf;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0] got_q[$];

  uart_tx_fifo dut (
    .Fifo_CLK          (clk),
    .Fifo_RST          (rst),
    .Fifo_Flush        (flush),
    .Fifo_WrEn         (wr),
    .Fifo_Pdata_in     (din),
    .Fifo_ParityEn_in  (pen),
    .Fifo_ParBit_in    (pbit),
    .Fifo_Full         (full),
    .Fifo_AlmostFull   (afull),
    .Fifo_Empty        (empty),
    .Uart_Busy_in      (busy),
    .Fifo_Pdata_out    (dout),
    .Fifo_ParityEn_out (pen_o),
    .Fifo_ParBit_out   (pbit_o),
    .Fifo_DataValid    (dv)
`ifdef TXFIFO_STATUS_EN
    ,
    .Fifo_Count        (count),
    .Fifo_Overflow     (ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, flush, wr;
    logic [7:0] din;
    logic       pen, pbit, busy;
    logic       e_empty, e_full, e_afull, e_dv;
    logic [7:0] e_dout;
    logic       e_pen, e_pbit;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic f, logic w, logic [7:0] d, logic p, logic pb,
                              logic b, logic ee, logic ef, logic ea, logic edv,
                              logic [7:0] ed, logic ep, logic epb);
    vec_t v;
    v.rst = r; v.flush = f; v.wr = w; v.din = d; v.pen = p; v.pbit = pb; v.busy = b;
    v.e_empty = ee; v.e_full = ef; v.e_afull = ea; v.e_dv = edv;
    v.e_dout = ed; v.e_pen = ep; v.e_pbit = epb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // One clock: inputs already driven; sample after the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic write_word(input logic [7:0] d);
    wr = 1'b1; din = d; pen = d[0]; pbit = d[1];
    step();
    wr = 1'b0;
  endtask

  // Transmitter model: raises Busy for 3 cycles after each strobe, captures words
  task automatic run_uart(input int n);
    int cnt = 0, bcnt = 0, cyc = 0;
    busy = 1'b0;
    while ((cnt < n || bcnt > 0) && cyc < 400) begin
      step();
      cyc++;
      if (dv) begin
        got_q.push_back(dout);
        cnt++;
        busy = 1'b1;
        bcnt = 3;
      end else if (bcnt > 0) begin
        bcnt--;
        if (bcnt == 0) busy = 1'b0;
      end
    end
    if (cyc >= 400) begin
      checks++;
      errors++;
      $display("FAIL uart_wait got %0d words expected %0d", cnt, n);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; wr = 1'b0; din = '0; pen = 1'b0; pbit = 1'b0; busy = 1'b0;

    // Reset with write active, then single word A5 and a follow-up word 3C
    tbl.push_back(mk(1,0,1,8'hFF,1,1,0, 1,0,0,0,8'h00,0,0));
    tbl.push_back(mk(1,0,1,8'hFF,1,1,0, 1,0,0,0,8'h00,0,0));
    tbl.push_back(mk(0,0,1,8'hA5,1,1,0, 0,0,0,0,8'h00,0,0));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 1,0,0,1,8'hA5,1,1));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 1,0,0,0,8'hA5,1,1));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0,0,0,8'h00,0,0,1, 1,0,0,0,8'hA5,1,1));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 1,0,0,0,8'hA5,1,1));
    tbl.push_back(mk(0,0,1,8'h3C,0,0,0, 0,0,0,0,8'hA5,1,1));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 1,0,0,1,8'h3C,0,0));
    tbl.push_back(mk(0,0,0,8'h00,0,0,0, 1,0,0,0,8'h3C,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; flush = tbl[i].flush; wr = tbl[i].wr; din = tbl[i].din;
      pen = tbl[i].pen; pbit = tbl[i].pbit; busy = tbl[i].busy;
      step();
      chk($sformatf("vec%0d", i),
          32'({empty, full, afull, dv, dout, pen_o, pbit_o}),
          32'({tbl[i].e_empty, tbl[i].e_full, tbl[i].e_afull, tbl[i].e_dv,
               tbl[i].e_dout, tbl[i].e_pen, tbl[i].e_pbit}));
    end
    wr = 1'b0; busy = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Fill with Busy held high: AlmostFull at 6, Full at 8, ninth write dropped
    busy = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      write_word(8'(k));
      chk($sformatf("fill_flags%0d", k), 32'({empty, afull, full}),
          32'({1'b0, (k >= 6), (k >= 8)}));
    end
`ifdef TXFIFO_STATUS_EN
    chk("fill_overflow", 32'(ovf), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
`endif
    got_q.delete();
    run_uart(8);
    chk("fill_drain_n", 32'(got_q.size()), 32'd8);
    for (int i = 0; i < got_q.size() && i < 8; i++)
      chk($sformatf("fill_word%0d", i), 32'(got_q[i]), 32'(i + 1));
    step();
    chk("fill_empty", 32'({empty, dv}), 32'b10);

    // Twenty write/issue rounds across the pointer wrap
    for (int i = 0; i < 20; i++) begin
      got_q.delete();
      write_word(8'(8'h10 + i));
      run_uart(1);
      chk($sformatf("wrap%0d", i), 32'(got_q.size() > 0 ? got_q[0] : 8'hXX), 32'(8'h10 + i));
    end

    // Timeout: Busy never rises; first word consumed, second issued 5 cycles later
    busy = 1'b0;
    step();
    wr = 1'b1; din = 8'h55; pen = 1'b0; pbit = 1'b0;
    step();
    din = 8'h66;
    step();
    wr = 1'b0;
    chk("tmo_first", 32'({dv, dout}), 32'({1'b1, 8'h55}));
    for (int k = 1; k <= 10; k++) begin
      step();
      chk($sformatf("tmo_dv%0d", k), 32'(dv), 32'(k == 5));
      if (k == 5) chk("tmo_second", 32'(dout), 32'h66);
    end
    chk("tmo_empty", 32'(empty), 32'd1);

    // Flush with three words queued, write asserted and issue about to happen
    busy = 1'b1;
    write_word(8'hA1);
    write_word(8'hA2);
    write_word(8'hA3);
    chk("flush_pre_empty", 32'(empty), 32'd0);
`ifdef TXFIFO_STATUS_EN
    chk("flush_pre_count", 32'(count), 32'd3);
`endif
    flush = 1'b1; wr = 1'b1; din = 8'hEE; busy = 1'b0;
    step();
    flush = 1'b0; wr = 1'b0;
    chk("flush_state", 32'({empty, full, dv, dout}), 32'({1'b1, 1'b0, 1'b0, 8'h66}));
`ifdef TXFIFO_STATUS_EN
    chk("flush_status", 32'({ovf, count}), 32'd0);
`endif
    for (int k = 0; k < 6; k++) begin
      step();
      chk($sformatf("flush_idle%0d", k), 32'({empty, dv}), 32'b10);
    end
    got_q.delete();
    write_word(8'h77);
    run_uart(1);
    chk("flush_after", 32'(got_q.size() > 0 ? got_q[0] : 8'hXX), 32'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
